// File: rtl/parity_pkg.sv
// Shared definitions for the even-parity serial link (transmitter and checker).
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/even_parity_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module bit_timer
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Restarting on tick keeps every bit period the same length inside multi-bit states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter: start(0), data LSB first, parity, stop(1).
//   state  | meaning
//   IDLE   | line high, in_ready high, waiting for a word
//   START  | driving the start bit
//   DATA   | driving shreg[0], one data bit per bit period
//   PARITY | driving the latched even parity bit
//   STOP   | driving the stop bit, done on its final cycle
module even_parity_serial_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              parity_out,
  output logic              busy,
  output logic              done
);

  localparam int IW = cnt_w(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  tx_state_t         state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              accept;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign done     = (state == STOP) && tick;

  // Held clear in IDLE so the first START period is a full one.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && (idx == LAST_IDX)) state_nxt = PARITY;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      idx        <= '0;
      parity_out <= 1'b0;
    end else begin
      if (accept) begin
        shreg      <= in_data;
        parity_out <= ^in_data;
      end
      if ((state == DATA) && tick) begin
        shreg <= shreg >> 1;
        idx   <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end
    end
  end

  always_comb begin
    tx = LINE_IDLE;
    case (state)
      IDLE:    tx = LINE_IDLE;
      START:   tx = START_BIT;
      DATA:    tx = shreg[0];
      PARITY:  tx = parity_out;
      STOP:    tx = STOP_BIT;
      default: tx = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Directed bench for even_parity_serial_tx at one and four clocks per bit.
module tb_even_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d1, d4;
  logic       v1, v4;
  logic       r1, tx1, p1, b1, dn1;
  logic       r4, tx4, p4, b4, dn4;

  int n_cmp = 0;
  int n_err = 0;

  logic exp_t1     [7]  = '{0, 1, 1, 0, 1, 1, 1};
  logic exp_t2_tx  [16] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
  logic exp_t2_rdy [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
  logic exp_t3     [7]  = '{0, 0, 1, 1, 0, 0, 1};

  logic [6:0] s;
  logic [4:0] f;
  int         idle_cnt, ndone, last_done;

  always #5 clk = ~clk;

  even_parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(r1),
    .tx(tx1), .parity_out(p1), .busy(b1), .done(dn1)
  );

  even_parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(r4),
    .tx(tx4), .parity_out(p4), .busy(b4), .done(dn4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready4(input string tag);
    for (int k = 0; k < 64 && r4 !== 1'b1; k++) step();
    chk(tag, r4, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; d1 = '0; d4 = '0; v1 = 1'b0; v4 = 1'b0;
    #2;
    chk("rst_tx1", tx1, 1); chk("rst_rdy1", r1, 1); chk("rst_busy1", b1, 0);
    chk("rst_done1", dn1, 0); chk("rst_par1", p1, 0);
    chk("rst_tx4", tx4, 1); chk("rst_busy4", b4, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1: single frame, one clock per bit
    d1 = 4'b1011; v1 = 1'b1;
    chk("t1_ready0", r1, 1);
    step();
    v1 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) step();
      chk($sformatf("t1_tx%0d", c), tx1, exp_t1[c-1]);
      chk($sformatf("t1_done%0d", c), dn1, (c == 7));
      if (c == 1) chk("t1_parity", p1, 1);
    end
    step();
    chk("t1_ready8", r1, 1);
    chk("t1_busy8", b1, 0);

    // 2: back-to-back 0000 then 1111 with in_valid held
    d1 = 4'b0000; v1 = 1'b1;
    step();
    idle_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) step();
      chk($sformatf("t2_tx%0d", c), tx1, exp_t2_tx[c-1]);
      chk($sformatf("t2_rdy%0d", c), r1, exp_t2_rdy[c-1]);
      if (c == 1 || c == 9) chk($sformatf("t2_par%0d", c), p1, 0);
      if (c == 7 || c == 15) chk($sformatf("t2_done%0d", c), dn1, 1);
      if (c >= 2 && c <= 15 && b1 == 1'b0) idle_cnt++;
      if (c == 1) d1 = 4'b1111;
      if (c == 9) v1 = 1'b0;
    end
    chk("t2_idle_gap", idle_cnt, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t2_no_extra", b1, 0);
    end

    // 3 and 4: four clocks per bit, with an ignored pulse while busy
    wait_ready4("t3_ready");
    d4 = 4'b0110; v4 = 1'b1;
    step();
    v4 = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      if (c > 1) step();
      chk($sformatf("t3_tx%0d", c), tx4, exp_t3[(c-1)/4]);
      chk($sformatf("t3_done%0d", c), dn4, (c == 28));
      chk($sformatf("t3_busy%0d", c), b4, 1);
      if (c == 1) chk("t3_parity", p4, 0);
      if (c == 10) begin d4 = 4'b0001; v4 = 1'b1; end
      if (c == 11) v4 = 1'b0;
    end
    step();
    chk("t3_ready29", r4, 1); chk("t3_busy29", b4, 0); chk("t3_tx29", tx4, 1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t4_no_extra", b4, 0);
      chk("t4_par_kept", p4, 0);
    end

    // 5: reset during DATA
    d4 = 4'b1110; v4 = 1'b1;
    step();
    v4 = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    chk("t5_tx_data", tx4, 0);
    chk("t5_busy_pre", b4, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_tx_rst", tx4, 1); chk("t5_busy_rst", b4, 0); chk("t5_rdy_rst", r4, 1);
    chk("t5_done_rst", dn4, 0); chk("t5_par_rst", p4, 0);
    step(); chk("t5_done_hold1", dn4, 0);
    step(); chk("t5_done_hold2", dn4, 0);
    rst_n = 1'b1;
    wait_ready4("t5_ready_after");
    d4 = 4'b0101; v4 = 1'b1;
    step();
    v4 = 1'b0;
    chk("t5_par_new", p4, 0);
    ndone = 0; last_done = 0;
    for (int c = 1; c <= 28; c++) begin
      if (c > 1) step();
      if (dn4 === 1'b1) begin ndone++; last_done = c; end
    end
    chk("t5_ndone", ndone, 1);
    chk("t5_done_cycle", last_done, 28);
    step();

    // 6: loopback through an even parity checker for every word
    for (int w = 0; w < 16; w++) begin
      wait_ready4($sformatf("t6_ready_w%0d", w));
      d4 = w[3:0]; v4 = 1'b1;
      step();
      v4 = 1'b0;
      s = '0;
      for (int c = 1; c <= 28; c++) begin
        if (c > 1) step();
        if ((c - 1) % 4 == 1) s[(c-1)/4] = tx4;
      end
      step();
      chk($sformatf("t6_start_w%0d", w), s[0], 0);
      chk($sformatf("t6_stop_w%0d", w), s[6], 1);
      chk($sformatf("t6_data_w%0d", w), s[4:1], w[3:0]);
      chk($sformatf("t6_check_w%0d", w), ^s[5:1], 0);
      f = s[5:1] ^ 5'b00100;
      chk($sformatf("t6_flip_w%0d", w), ^f, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
